// File: rtl/slv_guard_cfg_regs.sv
// -----------------------------------------------------------------------------
// slv_guard_cfg_regs
//
// Configuration and status register block for the AXI slave guard. A REG_BUS
// responder (two-state handshake, one access every two cycles) holds the guard
// configuration (CTRL, WRITE_BUDGET, READ_BUDGET). The timeout pulses coming
// back from the guard are collected into sticky STATUS bits, a saturating event
// counter and a last-ID capture. These in turn drive the registered interrupt
// and reset-request outputs.
//
// Ports
//   clk_i          : clock
//   rst_i          : synchronous, active-high reset
//   reg_req_i      : REG_BUS request  (addr, write, wdata, wstrb, valid)
//   reg_rsp_o      : REG_BUS response (rdata, error, ready)
//   wr_timeout_i   : one-cycle pulse, write transaction exceeded its budget
//   rd_timeout_i   : one-cycle pulse, read transaction exceeded its budget
//   timeout_id_i   : AXI ID of the timed-out transaction, valid with a pulse
//   guard_ena_o    : CTRL.enable
//   write_budget_o : WRITE_BUDGET register
//   read_budget_o  : READ_BUDGET register
//   irq_o          : interrupt, registered
//   rst_req_o      : reset request to the system, registered
// -----------------------------------------------------------------------------
package slv_guard_cfg_regs_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;

endpackage

module slv_guard_cfg_regs #(
    parameter int unsigned            AddrWidth   = 32,
    parameter int unsigned            IdWidth     = 4,
    parameter int unsigned            BudgetWidth = 16,
    parameter logic [BudgetWidth-1:0] WrBudgetRst = BudgetWidth'(16'h0010),
    parameter logic [BudgetWidth-1:0] RdBudgetRst = BudgetWidth'(16'h0010),
    parameter type                    reg_req_t   = slv_guard_cfg_regs_pkg::reg_req_t,
    parameter type                    reg_rsp_t   = slv_guard_cfg_regs_pkg::reg_rsp_t
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  reg_req_t               reg_req_i,
    output reg_rsp_t               reg_rsp_o,
    input  logic                   wr_timeout_i,
    input  logic                   rd_timeout_i,
    input  logic [IdWidth-1:0]     timeout_id_i,
    output logic                   guard_ena_o,
    output logic [BudgetWidth-1:0] write_budget_o,
    output logic [BudgetWidth-1:0] read_budget_o,
    output logic                   irq_o,
    output logic                   rst_req_o
);

    typedef enum logic {IDLE, RESP} state_e;

    typedef enum logic [2:0] {
        SEL_CTRL, SEL_WBUD, SEL_RBUD, SEL_STATUS, SEL_COUNT, SEL_LASTID, SEL_NONE
    } sel_e;

    // Byte-strobed merge of write data into an existing 32-bit register image.
    function automatic logic [31:0] strobe_merge(input logic [31:0] old_val,
                                                 input logic [31:0] wdata,
                                                 input logic [3:0]  wstrb);
        logic [31:0] merged;
        merged = old_val;
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) merged[8*b +: 8] = wdata[8*b +: 8];
        end
        return merged;
    endfunction

    state_e                 state_q, state_d;
    logic                   latch_req;

    // Latched request, held through RESP.
    sel_e                   sel_q;
    logic                   write_q;
    logic [31:0]            wdata_q;
    logic [3:0]             wstrb_q;
    logic [31:0]            rdata_q;
    logic                   err_q;

    // Register state.
    logic                   ena_q, irq_en_q, rst_on_to_q;
    logic [BudgetWidth-1:0] wbud_q, rbud_q;
    logic [1:0]             status_q;
    logic [15:0]            cnt_q;
    logic [IdWidth-1:0]     last_id_q;
    logic                   irq_q, rst_req_q;

    // Decode and read data for the incoming request.
    logic [AddrWidth-1:0]   req_word;
    sel_e                   sel_d;
    logic [31:0]            rdata_d;

    // Next-state terms.
    logic                   do_write;
    logic [1:0]             status_clr, status_d;
    logic [15:0]            cnt_base, cnt_d;
    logic [16:0]            cnt_sum;

    // NOTE: every signal written in always_comb gets a default first; a path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        req_word = AddrWidth'(reg_req_i.addr) & ~AddrWidth'(3);
        sel_d    = SEL_NONE;
        case (req_word)
            AddrWidth'(32'h00): sel_d = SEL_CTRL;
            AddrWidth'(32'h04): sel_d = SEL_WBUD;
            AddrWidth'(32'h08): sel_d = SEL_RBUD;
            AddrWidth'(32'h0C): sel_d = SEL_STATUS;
            AddrWidth'(32'h10): sel_d = SEL_COUNT;
            AddrWidth'(32'h14): sel_d = SEL_LASTID;
            default:            sel_d = SEL_NONE;
        endcase
    end

    // Read data is captured from the current register state when the request
    // is accepted, so an event in that same cycle is not yet visible.
    always_comb begin
        rdata_d = '0;
        case (sel_d)
            SEL_CTRL:   rdata_d = {29'b0, rst_on_to_q, irq_en_q, ena_q};
            SEL_WBUD:   rdata_d = 32'(wbud_q);
            SEL_RBUD:   rdata_d = 32'(rbud_q);
            SEL_STATUS: rdata_d = {30'b0, status_q};
            SEL_COUNT:  rdata_d = {16'b0, cnt_q};
            SEL_LASTID: rdata_d = 32'(last_id_q);
            default:    rdata_d = '0;
        endcase
    end

    // Handshake FSM: state register.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Handshake FSM: next state.
    always_comb begin
        state_d   = state_q;
        latch_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (reg_req_i.valid) begin
                    state_d   = RESP;
                    latch_req = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Writes take effect on the edge that closes the ready cycle.
    always_comb begin
        do_write   = (state_q == RESP) && write_q;
        status_clr = (do_write && sel_q == SEL_STATUS && wstrb_q[0]) ? wdata_q[1:0] : 2'b00;
        // Hardware set is OR-ed in after the clear, so it wins a collision.
        status_d   = (status_q & ~status_clr) | {rd_timeout_i, wr_timeout_i};
        // A write to TIMEOUT_COUNT clears it; same-cycle events still count.
        cnt_base   = (do_write && sel_q == SEL_COUNT) ? 16'h0 : cnt_q;
        cnt_sum    = {1'b0, cnt_base} + {16'b0, wr_timeout_i} + {16'b0, rd_timeout_i};
        cnt_d      = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sel_q       <= SEL_NONE;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            ena_q       <= 1'b0;
            irq_en_q    <= 1'b0;
            rst_on_to_q <= 1'b0;
            wbud_q      <= WrBudgetRst;
            rbud_q      <= RdBudgetRst;
            status_q    <= '0;
            cnt_q       <= '0;
            last_id_q   <= '0;
            irq_q       <= 1'b0;
            rst_req_q   <= 1'b0;
        end else begin
            if (latch_req) begin
                sel_q   <= sel_d;
                write_q <= reg_req_i.write;
                wdata_q <= reg_req_i.wdata;
                wstrb_q <= reg_req_i.wstrb;
                rdata_q <= rdata_d;
                err_q   <= (sel_d == SEL_NONE);
            end

            if (do_write && sel_q == SEL_CTRL && wstrb_q[0]) begin
                ena_q       <= wdata_q[0];
                irq_en_q    <= wdata_q[1];
                rst_on_to_q <= wdata_q[2];
            end
            // Bytes above BudgetWidth are dropped by the width cast.
            if (do_write && sel_q == SEL_WBUD)
                wbud_q <= BudgetWidth'(strobe_merge(32'(wbud_q), wdata_q, wstrb_q));
            if (do_write && sel_q == SEL_RBUD)
                rbud_q <= BudgetWidth'(strobe_merge(32'(rbud_q), wdata_q, wstrb_q));

            status_q <= status_d;
            cnt_q    <= cnt_d;
            if (wr_timeout_i || rd_timeout_i) last_id_q <= timeout_id_i;

            // Driven from the registered STATUS, hence two cycles after a pulse.
            irq_q     <= irq_en_q & (|status_q);
            rst_req_q <= ena_q & rst_on_to_q & (|status_q);
        end
    end

    always_comb begin
        reg_rsp_o       = '0;
        reg_rsp_o.rdata = rdata_q;
        reg_rsp_o.error = err_q;
        reg_rsp_o.ready = (state_q == RESP);
    end

    assign guard_ena_o    = ena_q;
    assign write_budget_o = wbud_q;
    assign read_budget_o  = rbud_q;
    assign irq_o          = irq_q;
    assign rst_req_o      = rst_req_q;

endmodule

// File: tb/tb_slv_guard_cfg_regs.sv
module tb_slv_guard_cfg_regs;
    import slv_guard_cfg_regs_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    reg_req_t    reg_req_i;
    reg_rsp_t    reg_rsp_o;
    logic        wr_timeout_i;
    logic        rd_timeout_i;
    logic [3:0]  timeout_id_i;
    logic        guard_ena_o;
    logic [15:0] write_budget_o;
    logic [15:0] read_budget_o;
    logic        irq_o;
    logic        rst_req_o;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        error;
        logic        chk_rdata;
        string       name;
    } exp_t;

    exp_t sb_q[$];

    slv_guard_cfg_regs #(
        .AddrWidth  (32),
        .IdWidth    (4),
        .BudgetWidth(16),
        .WrBudgetRst(16'h0010),
        .RdBudgetRst(16'h0010),
        .reg_req_t  (reg_req_t),
        .reg_rsp_t  (reg_rsp_t)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .reg_req_i     (reg_req_i),
        .reg_rsp_o     (reg_rsp_o),
        .wr_timeout_i  (wr_timeout_i),
        .rd_timeout_i  (rd_timeout_i),
        .timeout_id_i  (timeout_id_i),
        .guard_ena_o   (guard_ena_o),
        .write_budget_o(write_budget_o),
        .read_budget_o (read_budget_o),
        .irq_o         (irq_o),
        .rst_req_o     (rst_req_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_req(input logic [31:0] addr, input logic wr,
                             input logic [31:0] wdata, input logic [3:0] wstrb);
        reg_req_i.addr  = addr;
        reg_req_i.write = wr;
        reg_req_i.wdata = wdata;
        reg_req_i.wstrb = wstrb;
        reg_req_i.valid = 1'b1;
    endtask

    // Pop the oldest expectation and compare it with the response on the bus.
    task automatic score_response();
        exp_t e;
        e = sb_q.pop_front();
        n_tests++;
        if (reg_rsp_o.error !== e.error ||
            (e.chk_rdata && reg_rsp_o.rdata !== e.rdata)) begin
            $display("FAIL %s: got rdata=0x%08h error=%0b, want rdata=0x%08h error=%0b",
                     e.name, reg_rsp_o.rdata, reg_rsp_o.error, e.rdata, e.error);
            n_fail++;
        end
    endtask

    // One complete access: expectation is queued when the request is driven.
    task automatic bus_access(input string name, input logic [31:0] addr, input logic wr,
                              input logic [31:0] wdata, input logic [3:0] wstrb,
                              input logic [31:0] exp_rdata, input logic exp_err,
                              input logic chk_rdata);
        exp_t e;
        int   waited;
        bit   seen;
        e.rdata = exp_rdata; e.error = exp_err; e.chk_rdata = chk_rdata; e.name = name;
        sb_q.push_back(e);
        drive_req(addr, wr, wdata, wstrb);
        seen   = 1'b0;
        waited = 0;
        while (!seen && waited < 10) begin
            tick();
            waited++;
            if (reg_rsp_o.ready === 1'b1) seen = 1'b1;
        end
        reg_req_i.valid = 1'b0;
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no ready within %0d cycles", name, waited);
            void'(sb_q.pop_front());
        end else begin
            n_tests++;
            if (waited != 1) begin
                $display("FAIL %s latency: ready after %0d cycles, want 1", name, waited);
                n_fail++;
            end
            score_response();
        end
        tick();
        n_tests++;
        if (reg_rsp_o.ready !== 1'b0) begin
            $display("FAIL %s ready width: ready=%0b one cycle later, want 0", name, reg_rsp_o.ready);
            n_fail++;
        end
    endtask

    // Access with timeout pulses either on the accepting edge (at_resp=0) or
    // on the edge that applies the write (at_resp=1).
    task automatic access_with_event(input string name, input logic [31:0] addr, input logic wr,
                                     input logic [31:0] wdata, input logic [3:0] wstrb,
                                     input logic [31:0] exp_rdata, input logic chk_rdata,
                                     input logic ev_wr, input logic ev_rd,
                                     input logic [3:0] id, input logic at_resp);
        exp_t e;
        e.rdata = exp_rdata; e.error = 1'b0; e.chk_rdata = chk_rdata; e.name = name;
        sb_q.push_back(e);
        drive_req(addr, wr, wdata, wstrb);
        timeout_id_i = id;
        if (!at_resp) begin
            wr_timeout_i = ev_wr;
            rd_timeout_i = ev_rd;
        end
        tick();
        wr_timeout_i    = 1'b0;
        rd_timeout_i    = 1'b0;
        reg_req_i.valid = 1'b0;
        if (reg_rsp_o.ready !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: ready=%0b one cycle after valid, want 1", name, reg_rsp_o.ready);
            void'(sb_q.pop_front());
        end else begin
            score_response();
        end
        if (at_resp) begin
            wr_timeout_i = ev_wr;
            rd_timeout_i = ev_rd;
        end
        tick();
        wr_timeout_i = 1'b0;
        rd_timeout_i = 1'b0;
        n_tests++;
        if (reg_rsp_o.ready !== 1'b0) begin
            $display("FAIL %s ready width: ready=%0b, want 0", name, reg_rsp_o.ready);
            n_fail++;
        end
    endtask

    task automatic pulse(input logic wr, input logic rd, input logic [3:0] id);
        wr_timeout_i = wr;
        rd_timeout_i = rd;
        timeout_id_i = id;
        tick();
        wr_timeout_i = 1'b0;
        rd_timeout_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) tick();
        n_tests++;
        if (reg_rsp_o !== '0 || irq_o !== 1'b0 || rst_req_o !== 1'b0 || guard_ena_o !== 1'b0) begin
            $display("FAIL reset outputs: rsp=0x%h irq=%0b rst_req=%0b ena=%0b, want all 0",
                     reg_rsp_o, irq_o, rst_req_o, guard_ena_o);
            n_fail++;
        end
        n_tests++;
        if (write_budget_o !== 16'h0010 || read_budget_o !== 16'h0010) begin
            $display("FAIL reset budgets: wr=0x%h rd=0x%h, want 0x0010/0x0010",
                     write_budget_o, read_budget_o);
            n_fail++;
        end
        rst_i = 1'b0;
        tick();
        bus_access("rst_rd_wbud",   32'h04, 1'b0, 32'h0, 4'h0, 32'h0010, 1'b0, 1'b1);
        bus_access("rst_rd_status", 32'h0C, 1'b0, 32'h0, 4'h0, 32'h0000, 1'b0, 1'b1);
        bus_access("rst_rd_ctrl",   32'h00, 1'b0, 32'h0, 4'h0, 32'h0000, 1'b0, 1'b1);
        bus_access("rst_rd_count",  32'h10, 1'b0, 32'h0, 4'h0, 32'h0000, 1'b0, 1'b1);
        n_tests++;
        if (irq_o !== 1'b0) begin
            $display("FAIL reset irq: irq_o=%0b, want 0", irq_o);
            n_fail++;
        end
    endtask

    task automatic test_config();
        bus_access("cfg_ctrl", 32'h00, 1'b1, 32'h1,  4'h1, 32'h0, 1'b0, 1'b0);
        bus_access("cfg_wbud", 32'h04, 1'b1, 32'h1,  4'hF, 32'h0, 1'b0, 1'b0);
        bus_access("cfg_rbud", 32'h08, 1'b1, 32'h20, 4'hF, 32'h0, 1'b0, 1'b0);
        n_tests++;
        if (guard_ena_o !== 1'b1 || write_budget_o !== 16'h0001 || read_budget_o !== 16'h0020) begin
            $display("FAIL cfg outputs: ena=%0b wr=0x%h rd=0x%h, want 1/0x0001/0x0020",
                     guard_ena_o, write_budget_o, read_budget_o);
            n_fail++;
        end
    endtask

    task automatic test_partial_strobe();
        bus_access("strb_wr",     32'h08, 1'b1, 32'h0000ABCD, 4'h2, 32'h0, 1'b0, 1'b0);
        bus_access("strb_rd",     32'h08, 1'b0, 32'h0, 4'h0, 32'h0000AB20, 1'b0, 1'b1);
        bus_access("strb_hi_wr",  32'h04, 1'b1, 32'hFFFF0000, 4'hC, 32'h0, 1'b0, 1'b0);
        bus_access("strb_hi_rd",  32'h04, 1'b0, 32'h0, 4'h0, 32'h00000001, 1'b0, 1'b1);
        bus_access("strb_lowbit", 32'h05, 1'b0, 32'h0, 4'h0, 32'h00000001, 1'b0, 1'b1);
        bus_access("ctrl_rd",     32'h00, 1'b0, 32'h0, 4'h0, 32'h00000001, 1'b0, 1'b1);
    endtask

    task automatic test_timeout();
        bus_access("to_ctrl", 32'h00, 1'b1, 32'h7, 4'h1, 32'h0, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 4'h3);
        n_tests++;
        if (irq_o !== 1'b0 || rst_req_o !== 1'b0) begin
            $display("FAIL to_early: irq=%0b rst_req=%0b 1 cycle after pulse, want 0/0", irq_o, rst_req_o);
            n_fail++;
        end
        tick();
        n_tests++;
        if (irq_o !== 1'b1 || rst_req_o !== 1'b1) begin
            $display("FAIL to_out: irq=%0b rst_req=%0b 2 cycles after pulse, want 1/1", irq_o, rst_req_o);
            n_fail++;
        end
        bus_access("to_status", 32'h0C, 1'b0, 32'h0, 4'h0, 32'h1, 1'b0, 1'b1);
        bus_access("to_lastid", 32'h14, 1'b0, 32'h0, 4'h0, 32'h3, 1'b0, 1'b1);
        bus_access("to_count",  32'h10, 1'b0, 32'h0, 4'h0, 32'h1, 1'b0, 1'b1);
        bus_access("to_w1c",    32'h0C, 1'b1, 32'h1, 4'h1, 32'h0, 1'b0, 1'b0);
        n_tests++;
        if (irq_o !== 1'b1) begin
            $display("FAIL to_irq_hold: irq=%0b right at register update, want 1", irq_o);
            n_fail++;
        end
        tick();
        n_tests++;
        if (irq_o !== 1'b0 || rst_req_o !== 1'b0) begin
            $display("FAIL to_irq_clr: irq=%0b rst_req=%0b, want 0/0", irq_o, rst_req_o);
            n_fail++;
        end
        bus_access("to_status_clr", 32'h0C, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic test_enable_gating();
        bus_access("gate_ctrl", 32'h00, 1'b1, 32'h6, 4'h1, 32'h0, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 4'h9);
        tick();
        n_tests++;
        if (guard_ena_o !== 1'b0 || irq_o !== 1'b1 || rst_req_o !== 1'b0) begin
            $display("FAIL gate_out: ena=%0b irq=%0b rst_req=%0b, want 0/1/0", guard_ena_o, irq_o, rst_req_o);
            n_fail++;
        end
        bus_access("gate_status", 32'h0C, 1'b0, 32'h0, 4'h0, 32'h2, 1'b0, 1'b1);
        bus_access("gate_w1c",    32'h0C, 1'b1, 32'h3, 4'h1, 32'h0, 1'b0, 1'b0);
        bus_access("gate_count",  32'h10, 1'b0, 32'h0, 4'h0, 32'h2, 1'b0, 1'b1);
    endtask

    task automatic test_collision();
        access_with_event("col_w1c", 32'h0C, 1'b1, 32'h3, 4'h1, 32'h0, 1'b0,
                          1'b1, 1'b1, 4'h5, 1'b1);
        bus_access("col_status", 32'h0C, 1'b0, 32'h0, 4'h0, 32'h3, 1'b0, 1'b1);
        bus_access("col_count",  32'h10, 1'b0, 32'h0, 4'h0, 32'h4, 1'b0, 1'b1);
        bus_access("col_lastid", 32'h14, 1'b0, 32'h0, 4'h0, 32'h5, 1'b0, 1'b1);
        access_with_event("clr_vs_event", 32'h10, 1'b1, 32'h0, 4'h0, 32'h0, 1'b0,
                          1'b0, 1'b1, 4'h6, 1'b1);
        bus_access("clr_count", 32'h10, 1'b0, 32'h0, 4'h0, 32'h1, 1'b0, 1'b1);
        access_with_event("rd_vs_event", 32'h10, 1'b0, 32'h0, 4'h0, 32'h1, 1'b1,
                          1'b1, 1'b0, 4'h7, 1'b0);
        bus_access("rd_after_event", 32'h10, 1'b0, 32'h0, 4'h0, 32'h2, 1'b0, 1'b1);
    endtask

    task automatic test_saturation();
        bus_access("sat_clr", 32'h10, 1'b1, 32'h0, 4'hF, 32'h0, 1'b0, 1'b0);
        timeout_id_i = 4'hA;
        wr_timeout_i = 1'b1;
        rd_timeout_i = 1'b1;
        repeat (32767) tick();
        wr_timeout_i = 1'b0;
        rd_timeout_i = 1'b0;
        bus_access("sat_fffe", 32'h10, 1'b0, 32'h0, 4'h0, 32'hFFFE, 1'b0, 1'b1);
        pulse(1'b1, 1'b1, 4'hA);
        bus_access("sat_ffff", 32'h10, 1'b0, 32'h0, 4'h0, 32'hFFFF, 1'b0, 1'b1);
        pulse(1'b1, 1'b1, 4'hA);
        bus_access("sat_hold", 32'h10, 1'b0, 32'h0, 4'h0, 32'hFFFF, 1'b0, 1'b1);
    endtask

    task automatic test_error();
        bus_access("err_rd",      32'h40, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1);
        bus_access("err_wr",      32'h40, 1'b1, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 1'b0);
        bus_access("lastid_wr",   32'h14, 1'b1, 32'h0, 4'hF, 32'h0, 1'b0, 1'b0);
        bus_access("lastid_keep", 32'h14, 1'b0, 32'h0, 4'h0, 32'hA, 1'b0, 1'b1);
        n_tests++;
        if (write_budget_o !== 16'h0001 || read_budget_o !== 16'hAB20 || guard_ena_o !== 1'b0) begin
            $display("FAIL err_side_effect: wr=0x%h rd=0x%h ena=%0b, want 0x0001/0xAB20/0",
                     write_budget_o, read_budget_o, guard_ena_o);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid_access();
        bus_access("pre_rst_ctrl", 32'h00, 1'b1, 32'h1, 4'h1, 32'h0, 1'b0, 1'b0);
        drive_req(32'h04, 1'b1, 32'h0000FFFF, 4'hF);
        tick();
        n_tests++;
        if (reg_rsp_o.ready !== 1'b1) begin
            $display("FAIL mid_rst_resp: ready=%0b, want 1", reg_rsp_o.ready);
            n_fail++;
        end
        rst_i = 1'b1;
        reg_req_i.valid = 1'b0;
        tick();
        n_tests++;
        if (reg_rsp_o.ready !== 1'b0 || write_budget_o !== 16'h0010 ||
            read_budget_o !== 16'h0010 || guard_ena_o !== 1'b0) begin
            $display("FAIL mid_rst: ready=%0b wr=0x%h rd=0x%h ena=%0b, want 0/0x0010/0x0010/0",
                     reg_rsp_o.ready, write_budget_o, read_budget_o, guard_ena_o);
            n_fail++;
        end
        drive_req(32'h08, 1'b1, 32'h0000FFFF, 4'hF);
        tick();
        rst_i = 1'b0;
        reg_req_i.valid = 1'b0;
        n_tests++;
        if (reg_rsp_o.ready !== 1'b0) begin
            $display("FAIL rst_with_valid: ready=%0b, want 0", reg_rsp_o.ready);
            n_fail++;
        end
        tick();
        n_tests++;
        if (reg_rsp_o.ready !== 1'b0 || read_budget_o !== 16'h0010) begin
            $display("FAIL rst_drop: ready=%0b rd=0x%h, want 0/0x0010", reg_rsp_o.ready, read_budget_o);
            n_fail++;
        end
        bus_access("post_rst_count",  32'h10, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1);
        bus_access("post_rst_status", 32'h0C, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1);
        bus_access("post_rst_lastid", 32'h14, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1);
    endtask

    initial begin
        reg_req_i    = '0;
        wr_timeout_i = 1'b0;
        rd_timeout_i = 1'b0;
        timeout_id_i = '0;
        rst_i        = 1'b1;

        test_reset();
        test_config();
        test_partial_strobe();
        test_timeout();
        test_enable_gating();
        test_collision();
        test_saturation();
        test_error();
        test_reset_mid_access();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
